gene_net: RTL and testbench

GENE_NET -- requirements
Module: gene_net

---
 rtl/gene_net.sv | 41 ++++
 tb/tb_gene_net.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/gene_net.sv
// gene_net: 8-gene boolean network that iterates from a seed, with a saturating step count.
// A change on x_in reseeds the trajectory; otherwise the state advances by f() every edge.
module gene_net (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] x_in,
  output logic [7:0] x_out,
  output logic       fixed_pt,
  output logic [7:0] steps
);
  logic [7:0] state_q, state_d, seed_q, seed_d, steps_q, steps_d, f;
  logic       load;
  assign f = {state_q[6] & state_q[2] & ~state_q[0],
              state_q[1],
              (state_q[2] & ~state_q[0]) | (state_q[7] & ~state_q[6]),
              state_q[4] | state_q[0],
              ~state_q[6] & (state_q[3] | state_q[7]),
              state_q[5] & ~state_q[6] & ~state_q[2],
              state_q[6],
              state_q[0]};
  always_comb begin
    load    = x_in != seed_q;
    seed_d  = load ? x_in : seed_q;
    state_d = load ? x_in : f;
    steps_d = load ? 8'd0 : (f != state_q && steps_q != 8'hFF) ? steps_q + 8'd1 : steps_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= 8'h00;
      seed_q  <= 8'h00;
      steps_q <= 8'h00;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      steps_q <= steps_d;
    end
  end
  assign x_out    = state_q;
  assign steps    = steps_q;
  assign fixed_pt = f == state_q;
endmodule

// File: tb/tb_gene_net.sv
// tb_gene_net: directed checks of gene_net trajectories, step counting, reseeding and async reset.
module tb_gene_net;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] x_in;
  logic [7:0] x_out;
  logic       fixed_pt;
  logic [7:0] steps;
  int         n_checks = 0;
  int         n_fail = 0;

  gene_net dut (
    .clk(clk), .rst_n(rst_n), .x_in(x_in),
    .x_out(x_out), .fixed_pt(fixed_pt), .steps(steps)
  );

  always #5 clk = ~clk;

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    x_in  = 8'h00;
    #2;
    n_checks++;
    if ({x_out, steps, fixed_pt} !== {8'h00, 8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL reset: x_out=%h steps=%0d fp=%b, want x_out=00 steps=0 fp=1", x_out, steps, fixed_pt);
    end
    edge_wait();
    #2 rst_n = 1'b1;
  endtask

  task automatic test_quiet();
    for (int k = 0; k < 10; k++) begin
      edge_wait();
      n_checks++;
      if ({x_out, steps, fixed_pt} !== {8'h00, 8'h00, 1'b1}) begin
        n_fail++;
        $display("FAIL quiet[%0d]: x_out=%h steps=%0d fp=%b, want 00/0/1", k, x_out, steps, fixed_pt);
      end
    end
  endtask

  task automatic test_glitch();
    #2 x_in = 8'h38;
    #1 x_in = 8'h00;
    edge_wait();
    n_checks++;
    if ({x_out, steps} !== {8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL glitch: x_out=%h steps=%0d, want 00/0", x_out, steps);
    end
  endtask

  task automatic test_cycle38();
    x_in = 8'h38;
    edge_wait();
    n_checks++;
    if ({x_out, steps, fixed_pt} !== {8'h38, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL cycle38 load: x_out=%h steps=%0d fp=%b, want 38/0/0", x_out, steps, fixed_pt);
    end
    for (int k = 1; k <= 6; k++) begin
      edge_wait();
      n_checks++;
      if ({x_out, steps, fixed_pt} !== {(k % 2 == 1) ? 8'h1C : 8'h38, 8'(k), 1'b0}) begin
        n_fail++;
        $display("FAIL cycle38[%0d]: x_out=%h steps=%0d fp=%b, want %h/%0d/0",
                 k, x_out, steps, fixed_pt, (k % 2 == 1) ? 8'h1C : 8'h38, k);
      end
    end
  endtask

  task automatic test_basin63();
    logic [7:0] ex [3] = '{8'h63, 8'h53, 8'h53};
    logic [7:0] es [3] = '{8'd0, 8'd1, 8'd1};
    logic       ef [3] = '{1'b0, 1'b1, 1'b1};
    x_in = 8'h63;
    for (int k = 0; k < 3; k++) begin
      edge_wait();
      n_checks++;
      if ({x_out, steps, fixed_pt} !== {ex[k], es[k], ef[k]}) begin
        n_fail++;
        $display("FAIL basin63[%0d]: x_out=%h steps=%0d fp=%b, want %h/%0d/%b",
                 k, x_out, steps, fixed_pt, ex[k], es[k], ef[k]);
      end
    end
  endtask

  task automatic test_cycle7c();
    x_in = 8'h7C;
    for (int k = 0; k < 5; k++) begin
      edge_wait();
      n_checks++;
      if ({x_out, steps, fixed_pt} !== {(k % 2 == 0) ? 8'h7C : 8'hB2, 8'(k), 1'b0}) begin
        n_fail++;
        $display("FAIL cycle7c[%0d]: x_out=%h steps=%0d fp=%b, want %h/%0d/0",
                 k, x_out, steps, fixed_pt, (k % 2 == 0) ? 8'h7C : 8'hB2, k);
      end
    end
  endtask

  task automatic test_reload();
    logic [7:0] ex [4] = '{8'hFF, 8'h53, 8'h53, 8'h38};
    logic [7:0] es [4] = '{8'd0, 8'd1, 8'd1, 8'd0};
    logic       ef [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    x_in = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) x_in = 8'h38;
      edge_wait();
      n_checks++;
      if ({x_out, steps, fixed_pt} !== {ex[k], es[k], ef[k]}) begin
        n_fail++;
        $display("FAIL reload[%0d]: x_out=%h steps=%0d fp=%b, want %h/%0d/%b",
                 k, x_out, steps, fixed_pt, ex[k], es[k], ef[k]);
      end
    end
  endtask

  task automatic test_saturate();
    for (int k = 1; k <= 300; k++) begin
      edge_wait();
      if (k == 254 || k == 255 || k == 256 || k == 300) begin
        n_checks++;
        if ({x_out, steps} !== {(k % 2 == 1) ? 8'h1C : 8'h38, (k > 255) ? 8'd255 : 8'(k)}) begin
          n_fail++;
          $display("FAIL saturate[%0d]: x_out=%h steps=%0d, want %h/%0d",
                   k, x_out, steps, (k % 2 == 1) ? 8'h1C : 8'h38, (k > 255) ? 255 : k);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    edge_wait();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({x_out, steps, fixed_pt} !== {8'h00, 8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL async_reset: x_out=%h steps=%0d fp=%b, want 00/0/1", x_out, steps, fixed_pt);
    end
    #1 rst_n = 1'b1;
    edge_wait();
    n_checks++;
    if ({x_out, steps, fixed_pt} !== {8'h38, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL restart: x_out=%h steps=%0d fp=%b, want 38/0/0", x_out, steps, fixed_pt);
    end
    edge_wait();
    n_checks++;
    if ({x_out, steps} !== {8'h1C, 8'h01}) begin
      n_fail++;
      $display("FAIL restart step: x_out=%h steps=%0d, want 1C/1", x_out, steps);
    end
  endtask

  initial begin
    test_reset();
    test_quiet();
    test_glitch();
    test_cycle38();
    test_basin63();
    test_cycle7c();
    test_reload();
    test_saturate();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
